// File: rtl/vector_magnitude.sv
// -----------------------------------------------------------------------------
// vector_magnitude
//
// Multi-channel fixed-point Euclidean norm:
//     r = sqrt(x0^2 + x1^2 + ... + x(N-1)^2)
//
// A vector is accepted with a valid/ready handshake. Each channel is then
// squared by a single time-shared squarer, one channel per cycle, into an
// accumulator. The square root of the accumulator is computed
// digit-by-digit, one result bit per cycle, MSB first. A final cycle rescales
// the root to the output format and saturates it. The result is held on r/sat
// until the consumer takes it.
//
// Parameters
//   nOfInputs       number of channels N (>= 1)
//   inputWidth      bits per signed input channel
//   inputFracWidth  fractional bits of each input
//   outputWidth     bits of unsigned result r
//   outputFracWidth fractional bits of r (<= inputFracWidth)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high; clears all state immediately
//   in_valid   input vector present on x
//   in_ready   unit can accept (IDLE and reset low)
//   x          packed signed channels, channel i at [i*inputWidth +: inputWidth]
//   out_valid  result held on r/sat
//   out_ready  consumer takes the result
//   r          unsigned magnitude
//   sat        r was clipped to all-ones
//
// Latency: out_valid rises N + R + 1 rising edges after the accepting edge,
// where R = ceil(SW/2) and SW = 2*inputWidth + clog2(N).
// -----------------------------------------------------------------------------
module vector_magnitude #(
    parameter int nOfInputs       = 2,
    parameter int inputWidth      = 8,
    parameter int inputFracWidth  = 7,
    parameter int outputWidth     = 8,
    parameter int outputFracWidth = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [nOfInputs*inputWidth-1:0] x,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [outputWidth-1:0]          r,
    output logic                            sat
);

    // -------------------------------------------------------------------------
    // Derived widths
    // -------------------------------------------------------------------------
    // Guard bits for the sum of N squares; a single channel needs none.
    localparam int LOGN = (nOfInputs > 1) ? $clog2(nOfInputs) : 0;
    // Width of one exact square.
    localparam int PW   = 2 * inputWidth;
    // Width of the sum of squares.
    localparam int SW   = PW + LOGN;
    // Number of root bits, which is also the number of sqrt iterations.
    localparam int RW   = (SW + 1) / 2;
    // The radicand is padded to an even number of bits so that it can be
    // consumed two bits per iteration.
    localparam int RADW = 2 * RW;
    // The partial remainder never exceeds 2*root; after the 2-bit shift it
    // needs at most RW+3 bits.
    localparam int REMW = RW + 3;
    // Right shift that converts the root to the output fraction width.
    localparam int D    = inputFracWidth - outputFracWidth;
    // Scaled root is held wide enough to see every bit above outputWidth,
    // whether the root is wider or narrower than the output.
    localparam int VXW  = ((RW > outputWidth) ? RW : outputWidth) + 1;
    localparam int IDXW = (nOfInputs > 1) ? $clog2(nOfInputs) : 1;
    localparam int CNTW = $clog2(RW + 1);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SQUARE = 2'd1;
    localparam logic [1:0] ST_SQRT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]                      state_reg,     state_next;
    logic [nOfInputs*inputWidth-1:0] x_reg,         x_next;
    logic [SW-1:0]                   acc_reg,       acc_next;
    logic [IDXW-1:0]                 idx_reg,       idx_next;
    logic [CNTW-1:0]                 cnt_reg,       cnt_next;
    logic [RADW-1:0]                 rad_reg,       rad_next;
    logic [REMW-1:0]                 rem_reg,       rem_next;
    logic [RW-1:0]                   root_reg,      root_next;
    logic                            out_valid_reg, out_valid_next;
    logic [outputWidth-1:0]          r_reg,         r_next;
    logic                            sat_reg,       sat_next;

    // -------------------------------------------------------------------------
    // Channel unpacking and the shared squarer
    // -------------------------------------------------------------------------
    logic signed [inputWidth-1:0] chan [nOfInputs];

    genvar gi;
    generate
        for (gi = 0; gi < nOfInputs; gi++) begin : g_chan
            assign chan[gi] = x_reg[gi*inputWidth +: inputWidth];
        end
    endgenerate

    logic signed [inputWidth-1:0] chan_sel;
    logic signed [PW-1:0]         sel_ext;
    logic signed [PW-1:0]         prod;
    logic        [PW-1:0]         prod_u;
    logic        [SW-1:0]         acc_sum;

    assign chan_sel = chan[idx_reg];
    assign sel_ext  = {{inputWidth{chan_sel[inputWidth-1]}}, chan_sel};
    // A square is never negative and at most 2^(PW-2) (for the most negative
    // input), so the PW-bit signed product is exact and can be read unsigned.
    assign prod     = sel_ext * sel_ext;
    assign prod_u   = $unsigned(prod);
    assign acc_sum  = acc_reg + SW'(prod_u);

    // -------------------------------------------------------------------------
    // One digit-by-digit square-root iteration
    // -------------------------------------------------------------------------
    logic [REMW-1:0] rem_shift;
    logic [REMW-1:0] trial;
    logic            trial_fits;
    logic [REMW-1:0] rem_step;
    logic [RW-1:0]   root_step;

    // Bring down the next two radicand bits and try the digit 1, i.e.
    // subtract 4*root + 1 from the shifted remainder.
    assign rem_shift  = {rem_reg[REMW-3:0], rad_reg[RADW-1 -: 2]};
    assign trial      = REMW'({root_reg, 2'b01});
    assign trial_fits = (rem_shift >= trial);
    assign rem_step   = trial_fits ? (rem_shift - trial) : rem_shift;
    assign root_step  = (root_reg << 1) | RW'(trial_fits);

    // -------------------------------------------------------------------------
    // Output scaling and saturation of the finished root
    // -------------------------------------------------------------------------
    logic [VXW-1:0]         v_ext;
    logic                   sat_calc;
    logic [outputWidth-1:0] r_calc;

    assign v_ext    = VXW'(root_reg) >> D;
    assign sat_calc = |(v_ext >> outputWidth);
    assign r_calc   = sat_calc ? {outputWidth{1'b1}} : v_ext[outputWidth-1:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        acc_next       = acc_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        rad_next       = rad_reg;
        rem_next       = rem_reg;
        root_next      = root_reg;
        out_valid_next = out_valid_reg;
        r_next         = r_reg;
        sat_next       = sat_reg;

        case (state_reg)
            ST_IDLE: begin
                // in_ready is high whenever the flops are in IDLE, so a
                // present vector is always taken here.
                if (in_valid) begin
                    x_next     = x;
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = ST_SQUARE;
                end
            end

            ST_SQUARE: begin
                acc_next = acc_sum;
                if (idx_reg == IDXW'(nOfInputs - 1)) begin
                    // Hand the complete sum straight to the root engine.
                    rad_next   = RADW'(acc_sum);
                    rem_next   = '0;
                    root_next  = '0;
                    cnt_next   = '0;
                    state_next = ST_SQRT;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            ST_SQRT: begin
                if (cnt_reg == CNTW'(RW)) begin
                    // All root bits are known; this extra cycle registers the
                    // rescaled and saturated result.
                    r_next         = r_calc;
                    sat_next       = sat_calc;
                    out_valid_next = 1'b1;
                    state_next     = ST_DONE;
                end else begin
                    rem_next  = rem_step;
                    root_next = root_step;
                    rad_next  = rad_reg << 2;
                    cnt_next  = cnt_reg + 1'b1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            acc_reg       <= '0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            rad_reg       <= '0;
            rem_reg       <= '0;
            root_reg      <= '0;
            out_valid_reg <= 1'b0;
            r_reg         <= '0;
            sat_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            acc_reg       <= acc_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            rad_reg       <= rad_next;
            rem_reg       <= rem_next;
            root_reg      <= root_next;
            out_valid_reg <= out_valid_next;
            r_reg         <= r_next;
            sat_reg       <= sat_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Reset gates in_ready directly so it drops as soon as reset rises.
    assign in_ready  = (state_reg == ST_IDLE) && !reset;
    assign out_valid = out_valid_reg;
    assign r         = r_reg;
    assign sat       = sat_reg;

endmodule
